tqvp_serial_alu: RTL and testbench



---
 rtl/tqvp_serial_alu_pkg.sv | 45 ++++
 rtl/tqvp_serial_alu_if.sv | 19 +
 rtl/tqvp_serial_alu_nibble.sv | 21 ++
 rtl/tqvp_serial_alu.sv | 205 ++++++++++++++++++++
 tb/tb_tqvp_serial_alu.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tqvp_serial_alu_pkg.sv
// rtl/tqvp_serial_alu_pkg.sv - register map, bit indices, state and transfer-size definitions
package tqvp_serial_alu_pkg;

    localparam logic [5:0] ADDR_OPA    = 6'h00;
    localparam logic [5:0] ADDR_OPB    = 6'h04;
    localparam logic [5:0] ADDR_CTRL   = 6'h08;
    localparam logic [5:0] ADDR_RESULT = 6'h0C;
    localparam logic [5:0] ADDR_ACC    = 6'h10;
    localparam logic [5:0] ADDR_STATUS = 6'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SUB    = 1;
    localparam int CTRL_ACC_EN = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_CARRY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_ERR   = 4;

    localparam logic [1:0] XFER_BYTE = 2'b00;
    localparam logic [1:0] XFER_HALF = 2'b01;
    localparam logic [1:0] XFER_WORD = 2'b10;
    localparam logic [1:0] XFER_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Narrow writes replace only the low byte/half and keep the upper bits.
    function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size);
        case (size)
            XFER_BYTE: merge_write = {old_val[31:8], wdata[7:0]};
            XFER_HALF: merge_write = {old_val[31:16], wdata[15:0]};
            XFER_WORD: merge_write = wdata;
            default:   merge_write = old_val;
        endcase
    endfunction

endpackage

// File: rtl/tqvp_serial_alu_if.sv
// rtl/tqvp_serial_alu_if.sv - TinyQV peripheral register bus
interface tqvp_serial_alu_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_serial_alu_nibble.sv
// rtl/tqvp_serial_alu_nibble.sv - 4-bit adder slice with carry into bit 3 for overflow
module serial_add_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);
    logic [3:0] low;
    logic [1:0] high;

    // Split at bit 3 so the carry into the MSB of the nibble is visible.
    always_comb begin
        low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        high = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low[3]};
        sum  = {high[0], low[2:0]};
        c3   = low[3];
        cout = high[1];
    end
endmodule

// File: rtl/tqvp_serial_alu.sv
// rtl/tqvp_serial_alu.sv - nibble-serial 32-bit add/sub peripheral with accumulator
module tqvp_serial_alu
    import tqvp_serial_alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               ui_in,
    output logic [7:0]               uo_out,
    tqvp_serial_alu_if.slave         bus,
    output logic                     user_interrupt
);

    alu_state_t  state_q, state_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic [2:0]  ctrl_q, ctrl_d;            // {irq_en, acc_en, sub}
    logic [31:0] result_q, result_d, acc_q, acc_d;
    logic [31:0] wa_q, wa_d, wb_q, wb_d, sum_q, sum_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d, wsub_q, wsub_d, wacc_q, wacc_d;
    logic        flag_carry_q, flag_carry_d, flag_ovf_q, flag_ovf_d;
    logic        done_q, done_d, err_q, err_d, ui0_q, ui0_d;
    logic        rd_pend_q, rd_pend_d, data_ready_q, data_ready_d;
    logic [31:0] data_out_q, data_out_d;

    logic [3:0]  nib_sum;
    logic        nib_cout, nib_c3;
    logic        busy, wr_en, rd_en, ui_rise, start_req;
    logic [31:0] rdata;
    logic        unused_ui;

    assign unused_ui = ^ui_in[7:1];

    serial_add_nibble u_nibble (
        .a   (wa_q[3:0]),
        .b   (wb_q[3:0]),
        .cin (carry_q),
        .sum (nib_sum),
        .cout(nib_cout),
        .c3  (nib_c3)
    );

    assign busy = (state_q == RUN);

    // Register read mux; unmapped addresses return zero.
    always_comb begin
        rdata = 32'h0;
        case (bus.address)
            ADDR_OPA:    rdata = opa_q;
            ADDR_OPB:    rdata = opb_q;
            ADDR_CTRL:   rdata = {28'h0, ctrl_q, 1'b0};
            ADDR_RESULT: rdata = result_q;
            ADDR_ACC:    rdata = acc_q;
            ADDR_STATUS: rdata = {27'h0, err_q, flag_ovf_q, flag_carry_q, done_q, busy};
            default:     rdata = 32'h0;
        endcase
    end

    // Bus decode, FSM next state, serial datapath and read response.
    always_comb begin
        state_d      = state_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        acc_d        = acc_q;
        wa_d         = wa_q;
        wb_d         = wb_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        wsub_d       = wsub_q;
        wacc_d       = wacc_q;
        flag_carry_d = flag_carry_q;
        flag_ovf_d   = flag_ovf_q;
        done_d       = done_q;
        err_d        = err_q;
        ui0_d        = ui_in[0];
        rd_pend_d    = rd_pend_q;
        data_out_d   = data_out_q;
        data_ready_d = 1'b0;

        wr_en     = (bus.data_write_n != XFER_NONE);
        // A request still asserted while ready is high is the tail of the one just answered.
        rd_en     = (bus.data_read_n != XFER_NONE) && !wr_en && !data_ready_q;
        ui_rise   = ui_in[0] && !ui0_q;
        start_req = (wr_en && bus.address == ADDR_CTRL && bus.data_in[CTRL_START]) || ui_rise;

        if (wr_en) begin
            case (bus.address)
                ADDR_OPA:    opa_d  = merge_write(opa_q, bus.data_in, bus.data_write_n);
                ADDR_OPB:    opb_d  = merge_write(opb_q, bus.data_in, bus.data_write_n);
                ADDR_CTRL:   ctrl_d = bus.data_in[CTRL_IRQ_EN:CTRL_SUB];
                ADDR_ACC:    acc_d  = merge_write(acc_q, bus.data_in, bus.data_write_n);
                ADDR_STATUS: begin
                    if (bus.data_in[STAT_DONE]) done_d = 1'b0;
                    if (bus.data_in[STAT_ERR])  err_d  = 1'b0;
                end
                default: ;
            endcase
        end

        case (state_q)
            RUN: begin
                sum_d   = {nib_sum, sum_q[31:4]};
                wa_d    = {4'h0, wa_q[31:4]};
                wb_d    = {4'h0, wb_q[31:4]};
                carry_d = nib_cout;
                cnt_d   = cnt_q + 3'd1;
                if (start_req) err_d = 1'b0 | 1'b1;
                if (cnt_q == 3'd7) begin
                    state_d      = DONE;
                    result_d     = sum_d;
                    flag_carry_d = nib_cout ^ wsub_q;
                    flag_ovf_d   = nib_cout ^ nib_c3;
                    done_d       = 1'b1;
                    if (wacc_q) acc_d = acc_q + sum_d;
                end
            end
            default: begin
                // IDLE and DONE both accept a start; DONE otherwise falls back to IDLE.
                state_d = IDLE;
                if (start_req) begin
                    state_d = RUN;
                    wsub_d  = ctrl_d[0];
                    wacc_d  = ctrl_d[1];
                    wa_d    = opa_q;
                    wb_d    = ctrl_d[0] ? ~opb_q : opb_q;
                    carry_d = ctrl_d[0];
                    cnt_d   = 3'd0;
                    sum_d   = 32'h0;
                end
            end
        endcase

        if (rd_pend_q) begin
            if (!busy) begin
                rd_pend_d    = 1'b0;
                data_out_d   = result_q;
                data_ready_d = 1'b1;
            end
        end else if (rd_en) begin
            if (bus.address == ADDR_RESULT && busy) begin
                rd_pend_d = 1'b1;
            end else begin
                data_out_d   = rdata;
                data_ready_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            opa_q        <= 32'h0;
            opb_q        <= 32'h0;
            ctrl_q       <= 3'h0;
            result_q     <= 32'h0;
            acc_q        <= 32'h0;
            wa_q         <= 32'h0;
            wb_q         <= 32'h0;
            sum_q        <= 32'h0;
            cnt_q        <= 3'h0;
            carry_q      <= 1'b0;
            wsub_q       <= 1'b0;
            wacc_q       <= 1'b0;
            flag_carry_q <= 1'b0;
            flag_ovf_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ui0_q        <= 1'b0;
            rd_pend_q    <= 1'b0;
            data_out_q   <= 32'h0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            acc_q        <= acc_d;
            wa_q         <= wa_d;
            wb_q         <= wb_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            wsub_q       <= wsub_d;
            wacc_q       <= wacc_d;
            flag_carry_q <= flag_carry_d;
            flag_ovf_q   <= flag_ovf_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ui0_q        <= ui0_d;
            rd_pend_q    <= rd_pend_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_ready  = data_ready_q;
    assign uo_out          = {busy, done_q, flag_carry_q, flag_ovf_q, result_q[3:0]};
    assign user_interrupt  = done_q & ctrl_q[2];

endmodule

// File: tb/tb_tqvp_serial_alu.sv
// tb/tb_tqvp_serial_alu.sv - directed self-checking bench for tqvp_serial_alu
module tb_tqvp_serial_alu;
    import tqvp_serial_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic       user_interrupt;
    int         vectors = 0;
    int         miscompares = 0;

    tqvp_serial_alu_if bus_if ();

    tqvp_serial_alu dut (
        .clk           (clk),
        .rst           (rst),
        .ui_in         (ui_in),
        .uo_out        (uo_out),
        .bus           (bus_if),
        .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus_if.address      = a;
        bus_if.data_in      = d;
        bus_if.data_write_n = sz;
        tick();
        bus_if.data_write_n = XFER_NONE;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        int n;
        n = 0;
        bus_if.address     = a;
        bus_if.data_read_n = XFER_WORD;
        do begin
            tick();
            n++;
        end while (bus_if.data_ready !== 1'b1 && n < 20);
        d = bus_if.data_out;
        bus_if.data_read_n = XFER_NONE;
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL read_timeout addr=%h got no data_ready required within 20 cycles", a);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        vectors++;
        if (uo_out !== 8'h00 || user_interrupt !== 1'b0 || bus_if.data_ready !== 1'b0 || bus_if.data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got uo=%h irq=%b rdy=%b dout=%h required all 0", uo_out, user_interrupt, bus_if.data_ready, bus_if.data_out);
        end
        rd(ADDR_STATUS, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h required 0", d); end
        rd(ADDR_RESULT, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h required 0", d); end
    endtask

    task automatic test_add();
        logic [31:0] d;
        wr(ADDR_OPA, 32'h7FFF_FFFF, XFER_WORD);
        wr(ADDR_OPB, 32'h0000_0001, XFER_WORD);
        wr(ADDR_CTRL, 32'h1, XFER_WORD);
        vectors++;
        if (uo_out[7] !== 1'b1) begin miscompares++; $display("FAIL add_busy_after_start got %b required 1", uo_out[7]); end
        repeat (7) tick();
        vectors++;
        if (uo_out[7:6] !== 2'b10) begin miscompares++; $display("FAIL add_busy_cycle7 got busy/done=%b required 10", uo_out[7:6]); end
        tick();
        vectors++;
        if (uo_out !== 8'h50) begin miscompares++; $display("FAIL add_uo_out got %h required 50", uo_out); end
        rd(ADDR_RESULT, d);
        vectors++;
        if (d !== 32'h8000_0000) begin miscompares++; $display("FAIL add_result got %h required 80000000", d); end
        rd(ADDR_STATUS, d);
        vectors++;
        if (d !== 32'h0A) begin miscompares++; $display("FAIL add_status got %h required 0a", d); end
        wr(ADDR_STATUS, 32'h2, XFER_WORD);
        wr(ADDR_OPA, 32'hFFFF_FFFF, XFER_WORD);
        wr(ADDR_CTRL, 32'h1, XFER_WORD);
        repeat (8) tick();
        rd(ADDR_RESULT, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL wrap_result got %h required 0", d); end
        rd(ADDR_STATUS, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL wrap_status got %h required 06", d); end
        wr(ADDR_STATUS, 32'h2, XFER_WORD);
    endtask

    task automatic test_sub();
        logic [31:0] d;
        wr(ADDR_OPA, 32'h0, XFER_WORD);
        wr(ADDR_OPB, 32'h1, XFER_WORD);
        wr(ADDR_CTRL, 32'h3, XFER_WORD);
        repeat (8) tick();
        vectors++;
        if (uo_out !== 8'h6F) begin miscompares++; $display("FAIL sub_uo_out got %h required 6f", uo_out); end
        rd(ADDR_RESULT, d);
        vectors++;
        if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sub_result got %h required ffffffff", d); end
        rd(ADDR_STATUS, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL sub_status got %h required 06", d); end
        wr(ADDR_STATUS, 32'h2, XFER_WORD);
    endtask

    task automatic test_acc();
        logic [31:0] d;
        wr(ADDR_ACC, 32'h5, XFER_WORD);
        wr(ADDR_OPA, 32'h2, XFER_WORD);
        wr(ADDR_OPB, 32'h3, XFER_WORD);
        for (int i = 0; i < 3; i++) begin
            wr(ADDR_CTRL, 32'h5, XFER_WORD);
            repeat (8) tick();
        end
        rd(ADDR_ACC, d);
        vectors++;
        if (d !== 32'd20) begin miscompares++; $display("FAIL acc_total got %0d required 20", d); end
        rd(ADDR_CTRL, d);
        vectors++;
        if (d !== 32'h4) begin miscompares++; $display("FAIL ctrl_readback got %h required 4", d); end
        wr(ADDR_STATUS, 32'h2, XFER_WORD);
        wr(ADDR_CTRL, 32'h0, XFER_WORD);
    endtask

    task automatic test_pending_read();
        logic [31:0] d;
        logic [31:0] val;
        int          cnt;
        int          first;
        wr(ADDR_OPA, 32'h10, XFER_WORD);
        wr(ADDR_OPB, 32'h20, XFER_WORD);
        wr(ADDR_CTRL, 32'h1, XFER_WORD);
        wr(ADDR_OPA, 32'h999, XFER_WORD);
        wr(ADDR_CTRL, 32'h1, XFER_WORD);
        cnt   = 0;
        first = -1;
        val   = 32'h0;
        bus_if.address     = ADDR_RESULT;
        bus_if.data_read_n = XFER_WORD;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus_if.data_ready === 1'b1) begin
                cnt++;
                if (first < 0) begin
                    first = i;
                    val   = bus_if.data_out;
                    bus_if.data_read_n = XFER_NONE;
                end
            end
        end
        bus_if.data_read_n = XFER_NONE;
        vectors++;
        if (cnt !== 1) begin miscompares++; $display("FAIL pend_pulse_count got %0d required 1", cnt); end
        vectors++;
        if (first < 5) begin miscompares++; $display("FAIL pend_withheld got ready at cycle %0d required >= 5", first); end
        vectors++;
        if (val !== 32'h30) begin miscompares++; $display("FAIL pend_result got %h required 30", val); end
        rd(ADDR_STATUS, d);
        vectors++;
        if (d !== 32'h12) begin miscompares++; $display("FAIL busy_start_err got %h required 12", d); end
        wr(ADDR_STATUS, 32'h12, XFER_WORD);
        rd(ADDR_STATUS, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL status_clear got %h required 0", d); end
        wr(ADDR_CTRL, 32'h1, XFER_WORD);
        repeat (8) tick();
        rd(ADDR_RESULT, d);
        vectors++;
        if (d !== 32'h9B9) begin miscompares++; $display("FAIL opa_write_while_busy got %h required 9b9", d); end
        wr(ADDR_STATUS, 32'h2, XFER_WORD);
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int          n;
        wr(ADDR_OPA, 32'h1, XFER_WORD);
        wr(ADDR_OPB, 32'h1, XFER_WORD);
        wr(ADDR_CTRL, 32'h8, XFER_WORD);
        vectors++;
        if (user_interrupt !== 1'b0) begin miscompares++; $display("FAIL irq_idle got %b required 0", user_interrupt); end
        ui_in = 8'h01;
        tick();
        ui_in = 8'h00;
        n = 0;
        while (uo_out[6] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 20) begin miscompares++; $display("FAIL ui_start_done got no done required done within 20 cycles"); end
        vectors++;
        if (user_interrupt !== 1'b1) begin miscompares++; $display("FAIL irq_with_done got %b required 1", user_interrupt); end
        wr(ADDR_STATUS, 32'h2, XFER_WORD);
        vectors++;
        if (uo_out[6] !== 1'b0 || user_interrupt !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear got done=%b irq=%b required 0 0", uo_out[6], user_interrupt);
        end
        rd(ADDR_RESULT, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL ui_result got %h required 2", d); end
        wr(ADDR_CTRL, 32'h0, XFER_WORD);
    endtask

    task automatic test_narrow_write();
        logic [31:0] d;
        wr(ADDR_OPA, 32'h1234_5678, XFER_WORD);
        wr(ADDR_OPA, 32'hFFFF_FFAB, XFER_BYTE);
        rd(ADDR_OPA, d);
        vectors++;
        if (d !== 32'h1234_56AB) begin miscompares++; $display("FAIL byte_write got %h required 123456ab", d); end
        rd(6'h18, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got %h required 0", d); end
        wr(ADDR_OPB, 32'h1234_5678, XFER_WORD);
        wr(ADDR_OPB, 32'hFFFF_CDEF, XFER_HALF);
        rd(ADDR_OPB, d);
        vectors++;
        if (d !== 32'h1234_CDEF) begin miscompares++; $display("FAIL half_write got %h required 1234cdef", d); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        wr(ADDR_OPA, 32'h3, XFER_WORD);
        wr(ADDR_OPB, 32'h4, XFER_WORD);
        wr(ADDR_CTRL, 32'hD, XFER_WORD);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (uo_out !== 8'h00 || user_interrupt !== 1'b0 || bus_if.data_ready !== 1'b0 || bus_if.data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs got uo=%h irq=%b rdy=%b dout=%h required all 0", uo_out, user_interrupt, bus_if.data_ready, bus_if.data_out);
        end
        rd(ADDR_ACC, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL midrun_reset_acc got %h required 0", d); end
        rd(ADDR_OPA, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL midrun_reset_opa got %h required 0", d); end
        wr(ADDR_OPA, 32'h3, XFER_WORD);
        wr(ADDR_OPB, 32'h4, XFER_WORD);
        wr(ADDR_CTRL, 32'h1, XFER_WORD);
        repeat (8) tick();
        vectors++;
        if (uo_out !== 8'h47) begin miscompares++; $display("FAIL post_reset_uo_out got %h required 47", uo_out); end
        rd(ADDR_RESULT, d);
        vectors++;
        if (d !== 32'h7) begin miscompares++; $display("FAIL post_reset_result got %h required 7", d); end
    endtask

    initial begin
        rst                 = 1'b1;
        ui_in               = 8'h00;
        bus_if.address      = 6'h0;
        bus_if.data_in      = 32'h0;
        bus_if.data_write_n = XFER_NONE;
        bus_if.data_read_n  = XFER_NONE;
        test_reset();
        test_add();
        test_sub();
        test_acc();
        test_pending_read();
        test_irq();
        test_narrow_write();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
